// File: rtl/hsv_pkg.sv
// Shared types and sizes for the HSV divider arbiter: operand width, divider latency and the
// routing tag that travels alongside each divide.
package hsv_pkg;

  localparam int unsigned HSV_W           = 6;
  localparam int unsigned HSV_DIV_LATENCY = 6;

  typedef logic req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
    logic    dz;
  } hsv_tag_t;

  localparam int unsigned HSV_TAG_W = $bits(hsv_tag_t);

endpackage

// File: rtl/hsv_tag_pipe.sv
// Fixed-depth shift register with async reset and synchronous flush.
// Carries divide tags here; generic enough for sync/valid delay lines.
module hsv_tag_pipe #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (i_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/hsv_div_arbiter.sv
// Round-robin sharing of one pipelined divider between the hue and saturation requesters;
// each issue is tagged so its quotient/remainder returns to the right owner.
module hsv_div_arbiter
  import hsv_pkg::*;
#(
  parameter int unsigned W       = HSV_W,
  parameter int unsigned LATENCY = HSV_DIV_LATENCY
) (
  input  logic                         rgb_clk_in,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [W-1:0]                 req0_numer,
  input  logic [W-1:0]                 req0_denom,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [W-1:0]                 req1_numer,
  input  logic [W-1:0]                 req1_denom,
  output logic                         div_valid,
  output logic [W-1:0]                 div_numer,
  output logic [W-1:0]                 div_denom,
  input  logic [W-1:0]                 div_quot,
  input  logic [W-1:0]                 div_remain,
  output logic                         rsp0_valid,
  output logic [W-1:0]                 rsp0_quot,
  output logic [W-1:0]                 rsp0_remain,
  output logic                         rsp0_dz,
  output logic                         rsp1_valid,
  output logic [W-1:0]                 rsp1_quot,
  output logic [W-1:0]                 rsp1_remain,
  output logic                         rsp1_dz,
  output logic [$clog2(LATENCY+2):0]   inflight
);

  localparam int unsigned IW = $clog2(LATENCY + 2) + 1;

  logic     w_gnt0, w_gnt1, w_gnt_any, w_dz, w_rsp_any;
  req_id_t  w_gnt_id;
  logic [W-1:0] w_sel_numer, w_sel_denom;
  hsv_tag_t w_out_tag;

  req_id_t  r_last_grant;
  hsv_tag_t r_iss_tag;
  logic [W-1:0] r_div_numer, r_div_denom;
  logic     r_rsp0_valid, r_rsp0_dz, r_rsp1_valid, r_rsp1_dz;
  logic [W-1:0] r_rsp0_quot, r_rsp0_remain, r_rsp1_quot, r_rsp1_remain;
  logic [IW-1:0] r_inflight;

  // Contention goes to whoever was not granted last
  assign w_gnt0      = req0_valid & (~req1_valid | (r_last_grant == req_id_t'(1'b1)));
  assign w_gnt1      = req1_valid & (~req0_valid | (r_last_grant == req_id_t'(1'b0)));
  assign w_gnt_any   = w_gnt0 | w_gnt1;
  assign w_gnt_id    = req_id_t'(w_gnt1);
  assign w_sel_numer = w_gnt1 ? req1_numer : req0_numer;
  assign w_sel_denom = w_gnt1 ? req1_denom : req0_denom;
  assign w_dz        = (w_sel_denom == '0);
  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;

  always_ff @(posedge rgb_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= req_id_t'(1'b1);
    end else if (w_gnt_any) begin
      r_last_grant <= w_gnt_id;
    end
  end

  // Issue stage; a zero divisor is replaced by a harmless 0/1 and flagged in the tag
  always_ff @(posedge rgb_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_tag   <= '0;
      r_div_numer <= '0;
      r_div_denom <= '0;
    end else if (flush) begin
      r_iss_tag   <= '0;
    end else if (w_gnt_any) begin
      r_iss_tag   <= '{v: 1'b1, id: w_gnt_id, dz: w_dz};
      r_div_numer <= w_dz ? '0 : w_sel_numer;
      r_div_denom <= w_dz ? W'(1) : w_sel_denom;
    end else begin
      r_iss_tag   <= '0;
    end
  end

  hsv_tag_pipe #(
    .DEPTH (LATENCY),
    .WIDTH (HSV_TAG_W)
  ) u_tag_pipe (
    .i_clk   (rgb_clk_in),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_data  (r_iss_tag),
    .o_data  (w_out_tag)
  );

  // Response stage; data holds between pulses
  always_ff @(posedge rgb_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_quot   <= '0;
      r_rsp0_remain <= '0;
      r_rsp0_dz     <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_quot   <= '0;
      r_rsp1_remain <= '0;
      r_rsp1_dz     <= 1'b0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      if (!flush && w_out_tag.v) begin
        if (w_out_tag.id == req_id_t'(1'b0)) begin
          r_rsp0_valid  <= 1'b1;
          r_rsp0_quot   <= w_out_tag.dz ? '0 : div_quot;
          r_rsp0_remain <= w_out_tag.dz ? '0 : div_remain;
          r_rsp0_dz     <= w_out_tag.dz;
        end else begin
          r_rsp1_valid  <= 1'b1;
          r_rsp1_quot   <= w_out_tag.dz ? '0 : div_quot;
          r_rsp1_remain <= w_out_tag.dz ? '0 : div_remain;
          r_rsp1_dz     <= w_out_tag.dz;
        end
      end
    end
  end

  assign w_rsp_any = r_rsp0_valid | r_rsp1_valid;

  always_ff @(posedge rgb_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (flush) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= r_inflight + IW'(w_gnt_any) - IW'(w_rsp_any);
    end
  end

  assign div_valid   = r_iss_tag.v;
  assign div_numer   = r_div_numer;
  assign div_denom   = r_div_denom;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_quot   = r_rsp0_quot;
  assign rsp0_remain = r_rsp0_remain;
  assign rsp0_dz     = r_rsp0_dz;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_quot   = r_rsp1_quot;
  assign rsp1_remain = r_rsp1_remain;
  assign rsp1_dz     = r_rsp1_dz;
  assign inflight    = r_inflight;

endmodule

// File: tb/tb_hsv_div_arbiter.sv
// Bench for hsv_div_arbiter: latency-6 divider model, per-cycle reference model of grants and
// pending results, a grant table, hand-written corner sequences and a randomized run.
module tb_hsv_div_arbiter;

  localparam int unsigned W   = 6;
  localparam int unsigned LAT = 6;

  logic clk = 1'b0;
  logic rst_n, flush;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_numer, req0_denom, req1_numer, req1_denom;
  logic div_valid;
  logic [W-1:0] div_numer, div_denom, div_quot, div_remain;
  logic rsp0_valid, rsp0_dz, rsp1_valid, rsp1_dz;
  logic [W-1:0] rsp0_quot, rsp0_remain, rsp1_quot, rsp1_remain;
  logic [3:0] inflight;

  always #5 clk = ~clk;

  hsv_div_arbiter dut (
    .rgb_clk_in (clk),        .rst_n      (rst_n),      .flush      (flush),
    .req0_valid (req0_valid), .req0_ready (req0_ready), .req0_numer (req0_numer),
    .req0_denom (req0_denom), .req1_valid (req1_valid), .req1_ready (req1_ready),
    .req1_numer (req1_numer), .req1_denom (req1_denom), .div_valid  (div_valid),
    .div_numer  (div_numer),  .div_denom  (div_denom),  .div_quot   (div_quot),
    .div_remain (div_remain), .rsp0_valid (rsp0_valid), .rsp0_quot  (rsp0_quot),
    .rsp0_remain(rsp0_remain),.rsp0_dz    (rsp0_dz),    .rsp1_valid (rsp1_valid),
    .rsp1_quot  (rsp1_quot),  .rsp1_remain(rsp1_remain),.rsp1_dz    (rsp1_dz),
    .inflight   (inflight)
  );

  // Divider model: operands present at the issue cycle come out LAT cycles later
  logic [W-1:0] dn [LAT];
  logic [W-1:0] dd [LAT];
  always @(posedge clk) begin
    dn[0] <= div_numer;
    dd[0] <= div_denom;
    for (int i = 1; i < LAT; i++) begin
      dn[i] <= dn[i-1];
      dd[i] <= dd[i-1];
    end
  end
  assign div_quot   = (dd[LAT-1] == '0) ? '0 : dn[LAT-1] / dd[LAT-1];
  assign div_remain = (dd[LAT-1] == '0) ? '0 : dn[LAT-1] % dd[LAT-1];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of accepted operations with the cycle their result is due
  typedef struct { int id; int due; int q; int r; int dz; } pend_t;
  pend_t pq[$];
  int cyc = 0;
  int m_last = 1;
  bit m_iss_v = 0;
  int m_iss_n = 0, m_iss_d = 0;
  int hq[2] = '{0, 0};
  int hr[2] = '{0, 0};
  int hd[2] = '{0, 0};
  int g_last = -1;

  task automatic model_reset();
    pq.delete();
    m_last = 1;
    m_iss_v = 0;
    for (int i = 0; i < 2; i++) begin hq[i] = 0; hr[i] = 0; hd[i] = 0; end
  endtask

  // One clock cycle: drive, check everything at the negedge, advance the model
  task automatic tick(input bit v0, input int n0, input int d0,
                      input bit v1, input int n1, input int d1, input bit fl);
    int g, n, d;
    logic [W-1:0] a_q [2];
    logic [W-1:0] a_r [2];
    logic a_v [2];
    logic a_d [2];
    req0_valid = v0; req0_numer = W'(n0); req0_denom = W'(d0);
    req1_valid = v1; req1_numer = W'(n1); req1_denom = W'(d1);
    flush = fl;
    @(negedge clk);
    while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
    chk("inflight", 32'(inflight), 32'(pq.size()));
    a_v[0] = rsp0_valid; a_q[0] = rsp0_quot; a_r[0] = rsp0_remain; a_d[0] = rsp0_dz;
    a_v[1] = rsp1_valid; a_q[1] = rsp1_quot; a_r[1] = rsp1_remain; a_d[1] = rsp1_dz;
    for (int k = 0; k < 2; k++) begin
      if (pq.size() > 0 && pq[0].due == cyc && pq[0].id == k) begin
        hq[k] = pq[0].q; hr[k] = pq[0].r; hd[k] = pq[0].dz;
        chk($sformatf("rsp%0d_valid", k), 32'(a_v[k]), 1);
      end else begin
        chk($sformatf("rsp%0d_valid", k), 32'(a_v[k]), 0);
      end
      chk($sformatf("rsp%0d_quot", k), 32'(a_q[k]), 32'(hq[k]));
      chk($sformatf("rsp%0d_remain", k), 32'(a_r[k]), 32'(hr[k]));
      chk($sformatf("rsp%0d_dz", k), 32'(a_d[k]), 32'(hd[k]));
    end
    chk("div_valid", 32'(div_valid), 32'(m_iss_v));
    if (m_iss_v) begin
      chk("div_numer", 32'(div_numer), 32'(m_iss_n));
      chk("div_denom", 32'(div_denom), 32'(m_iss_d));
    end
    if (v0 && v1) g = (m_last == 1) ? 0 : 1;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    else          g = -1;
    g_last = g;
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    m_iss_v = (g >= 0) && !fl;
    if (g >= 0) begin
      n = (g == 0) ? n0 : n1;
      d = (g == 0) ? d0 : d1;
      m_last = g;
      if (m_iss_v) begin
        m_iss_n = (d == 0) ? 0 : n;
        m_iss_d = (d == 0) ? 1 : d;
        pq.push_back('{id: g, due: cyc + LAT + 2,
                       q: (d == 0) ? 0 : n / d, r: (d == 0) ? 0 : n % d, dz: (d == 0)});
      end
    end
    if (fl) pq.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_div_valid"}, 32'(div_valid), 0);
    chk({tag, "_div_numer"}, 32'(div_numer), 0);
    chk({tag, "_rsp0_valid"}, 32'(rsp0_valid), 0);
    chk({tag, "_rsp1_valid"}, 32'(rsp1_valid), 0);
    chk({tag, "_rsp0_quot"}, 32'(rsp0_quot), 0);
    chk({tag, "_rsp1_remain"}, 32'(rsp1_remain), 0);
    chk({tag, "_inflight"}, 32'(inflight), 0);
  endtask

  typedef struct { bit v0; int n0; int d0; bit v1; int n1; int d1; bit r0; bit r1; } vec_t;
  vec_t tbl[9];

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    req0_valid = 1'b0; req0_numer = '0; req0_denom = '0;
    req1_valid = 1'b0; req1_numer = '0; req1_denom = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_ready0", 32'(req0_ready), 0);
    rst_n = 1'b1;
    model_reset();

    // Test 1: single req0 20/6 returns 3 r2 eight cycles later
    tick(1, 20, 6, 0, 0, 0, 0);
    chk("t1_div_valid", 32'(div_valid), 1);
    idle(7);
    chk("t1_rsp0_valid", 32'(rsp0_valid), 1);
    chk("t1_rsp0_quot", 32'(rsp0_quot), 3);
    chk("t1_rsp0_remain", 32'(rsp0_remain), 2);
    chk("t1_rsp0_dz", 32'(rsp0_dz), 0);
    idle(2);

    // Test 2: both requesters for four cycles alternate 1,0,1,0 (req0 granted last in test 1)
    tick(1, 10, 3, 1, 40, 7, 0);
    tick(1, 11, 3, 1, 41, 7, 0);
    tick(1, 12, 3, 1, 42, 7, 0);
    tick(1, 13, 3, 1, 43, 7, 0);
    chk("t2_inflight_peak", 32'(inflight), 4);
    idle(10);

    // Test 3: divide-by-zero on req1
    tick(0, 0, 0, 1, 13, 0, 0);
    chk("t3_div_numer", 32'(div_numer), 0);
    chk("t3_div_denom", 32'(div_denom), 1);
    idle(7);
    chk("t3_rsp1_valid", 32'(rsp1_valid), 1);
    chk("t3_rsp1_dz", 32'(rsp1_dz), 1);
    chk("t3_rsp1_quot", 32'(rsp1_quot), 0);
    chk("t3_rsp1_remain", 32'(rsp1_remain), 0);
    idle(2);

    // Test 4: sixteen back-to-back req0 operations; inflight saturates at LAT+2
    for (int i = 0; i < 16; i++) tick(1, 63 - i, i + 1, 0, 0, 0, 0);
    chk("t4_inflight_sat", 32'(inflight), 8);
    idle(10);

    // Test 5: flush with two operations in the divider
    tick(1, 30, 4, 0, 0, 0, 0);
    tick(1, 31, 5, 0, 0, 0, 0);
    idle(2);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("t5_inflight_flushed", 32'(inflight), 0);
    idle(10);
    tick(1, 9, 4, 0, 0, 0, 0);
    idle(7);
    chk("t5_rsp0_valid", 32'(rsp0_valid), 1);
    chk("t5_rsp0_quot", 32'(rsp0_quot), 2);
    chk("t5_rsp0_remain", 32'(rsp0_remain), 1);
    idle(2);

    // Test 6: reset mid-stream, then req0 must win first
    tick(1, 50, 7, 1, 20, 3, 0);
    tick(1, 51, 7, 1, 21, 3, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("t6_held");
    rst_n = 1'b1;
    model_reset();
    tick(1, 5, 2, 1, 6, 2, 0);
    chk("t6_first_grant", 32'(g_last), 0);
    idle(10);

    // Grant table from reset state
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    tbl[0] = '{1, 20, 6, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 21, 5, 1, 33, 4, 0, 1};
    tbl[2] = '{1, 22, 5, 1, 34, 4, 1, 0};
    tbl[3] = '{1, 23, 5, 1, 35, 4, 0, 1};
    tbl[4] = '{0, 0, 0, 1, 13, 0, 0, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 60, 0, 1, 61, 9, 1, 0};
    tbl[7] = '{1, 62, 8, 0, 0, 0, 1, 0};
    tbl[8] = '{1, 63, 1, 1, 7, 7, 0, 1};
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].v0, tbl[i].n0, tbl[i].d0, tbl[i].v1, tbl[i].n1, tbl[i].d1, 0);
      chk($sformatf("tbl%0d_gnt0", i), 32'(g_last == 0), 32'(tbl[i].r0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(g_last == 1), 32'(tbl[i].r1));
    end
    idle(10);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      bit fl, v0, v1;
      int d0, d1;
      fl = ($urandom_range(0, 39) == 0);
      v0 = !fl && ($urandom_range(0, 9) < 6);
      v1 = !fl && ($urandom_range(0, 9) < 6);
      d0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      d1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      tick(v0, int'($urandom_range(0, 63)), d0, v1, int'($urandom_range(0, 63)), d1, fl);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
